// File: rtl/tse_pkg.sv
// Shared definitions for the tristate enable sequencer.
//
// Contents:
//   N_DRV_MAX - largest supported number of drivers
//   HOLD_W    - width of the per-owner hold counter
//   GAP_W     - width of the turnaround gap counter
//   state_t   - FSM state encoding (StIdle, StDrive, StGap)
//   idx_w()   - index width for n items, never less than 1 bit

package tse_pkg;

    localparam int unsigned N_DRV_MAX = 8;
    localparam int unsigned HOLD_W    = 8;
    localparam int unsigned GAP_W     = 4;

    typedef logic [1:0] state_t;

    localparam state_t StIdle  = 2'd0;
    localparam state_t StDrive = 2'd1;
    localparam state_t StGap   = 2'd2;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin selector (purely combinational).
//
// Finds the first set bit of req, searching upward from pointer+1 and wrapping
// around, so the bit at pointer itself has the lowest priority.
//
// Ports:
//   req     - in,  N bits : candidate requests
//   pointer - in,  IW bits: index of the most recent winner
//   hit     - out, 1 bit  : at least one request is set
//   idx     - out, IW bits: index of the selected request (0 when hit=0)

module rr_pick
    import tse_pkg::*;
#(
    parameter int unsigned N  = 2,
    parameter int unsigned IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] pointer,
    output logic          hit,
    output logic [IW-1:0] idx
);

    int j;

    // Walk the offsets from farthest to nearest; the last match written is the
    // nearest one after pointer, which is the round-robin winner.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        j   = 0;
        for (int off = int'(N); off >= 1; off--) begin
            j = (int'(pointer) + off) % int'(N);
            if (req[j]) begin
                hit = 1'b1;
                idx = IW'(j);
            end
        end
    end

endmodule

// File: rtl/tristate_enable_sequencer.sv
// Output-enable sequencer for N tristate drivers sharing one bus net.
//
// Grants the bus to one requester at a time in round-robin order, forces a
// release after HOLD_MAX cycles when someone else is waiting, and inserts
// GAP_CYCLES clocks of all-zero enables between owners so the previous driver
// has reached high-Z before the next one turns on.
//
// Ports:
//   clk        - in,  1      : clock, rising edge
//   rst_n      - in,  1      : synchronous active-low reset
//   req        - in,  N_DRV  : level request per driver
//   en         - out, N_DRV  : registered tristate enables, one-hot or zero
//   grant_id   - out, idx_w  : index of current owner, qualify with busy
//   busy       - out, 1      : some enable is high
//   turnaround - out, 1      : dead-time gap in progress

module tristate_enable_sequencer
    import tse_pkg::*;
#(
    parameter int unsigned N_DRV      = 2,
    parameter int unsigned GAP_CYCLES = 2,
    parameter int unsigned HOLD_MAX   = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_DRV-1:0]          req,
    output logic [N_DRV-1:0]          en,
    output logic [idx_w(N_DRV)-1:0]   grant_id,
    output logic                      busy,
    output logic                      turnaround
);

    localparam int unsigned GW = idx_w(N_DRV);

    // Elaboration-time parameter range checks.
    if (GAP_CYCLES < 1 || GAP_CYCLES > 15) begin : g_bad_gap
        $error("GAP_CYCLES must be in 1..15");
    end
    if (N_DRV < 2 || N_DRV > N_DRV_MAX) begin : g_bad_ndrv
        $error("N_DRV must be in 2..8");
    end
    if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold
        $error("HOLD_MAX must be in 1..255");
    end

    state_t              state_q, state_d;
    logic [GW-1:0]       ptr_q, ptr_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [N_DRV-1:0]    en_q, en_d;
    logic [GW-1:0]       gid_q, gid_d;

    logic                pick_hit;
    logic [GW-1:0]       pick_idx;
    logic                owner_req;
    logic                others_req;
    logic                hold_at_max;

    rr_pick #(
        .N  (N_DRV),
        .IW (GW)
    ) u_pick (
        .req     (req),
        .pointer (ptr_q),
        .hit     (pick_hit),
        .idx     (pick_idx)
    );

    assign owner_req   = |(req & en_q);
    assign others_req  = |(req & ~en_q);
    assign hold_at_max = (hold_q >= HOLD_W'(HOLD_MAX));

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        gap_d   = gap_q;
        en_d    = en_q;
        gid_d   = gid_q;

        case (state_q)
            StIdle: begin
                if (pick_hit) begin
                    state_d = StDrive;
                    en_d    = N_DRV'(1) << pick_idx;
                    gid_d   = pick_idx;
                    ptr_d   = pick_idx;
                    // Counts DRIVE cycles including the first one.
                    hold_d  = HOLD_W'(1);
                end
            end

            StDrive: begin
                if (!hold_at_max) begin
                    hold_d = hold_q + HOLD_W'(1);
                end
                // A lone owner may keep the bus indefinitely; the hold limit
                // only bites when another driver is waiting.
                if (!owner_req || (hold_at_max && others_req)) begin
                    state_d = StGap;
                    en_d    = '0;
                    gap_d   = GAP_W'(GAP_CYCLES - 1);
                end
            end

            StGap: begin
                if (gap_q != '0) begin
                    gap_d = gap_q - GAP_W'(1);
                end else if (pick_hit) begin
                    state_d = StDrive;
                    en_d    = N_DRV'(1) << pick_idx;
                    gid_d   = pick_idx;
                    ptr_d   = pick_idx;
                    hold_d  = HOLD_W'(1);
                end else begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
                en_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            // Pointer at the top index so driver 0 wins first after reset.
            ptr_q   <= GW'(N_DRV - 1);
            hold_q  <= '0;
            gap_q   <= '0;
            en_q    <= '0;
            gid_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            gap_q   <= gap_d;
            en_q    <= en_d;
            gid_q   <= gid_d;
        end
    end

    assign en         = en_q;
    assign grant_id   = gid_q;
    assign busy       = |en_q;
    assign turnaround = (state_q == StGap);

endmodule

// File: doc/tristate_enable_sequencer.md
Name: tristate_enable_sequencer

Overview:
- Generates the output-enable lines for N tristate drivers that share one bus net.
- Gives each requester exclusive ownership of the bus and keeps ownership fair with a round-robin rule.
- Between any driver releasing the bus and the next driver enabling, inserts GAP_CYCLES of dead time with every enable low. This covers the driver's enable-to-Z delay and prevents contention.
- Sits on the controller side of the gated AND/OR tristate cells: its en outputs feed their enable pins.

Parameters:
- N_DRV, 2, number of tristate drivers/requesters (2..8).
- GAP_CYCLES, 2, bus turnaround dead time in clocks (1..15); 0 is illegal, enforced by elaboration-time check.
- HOLD_MAX, 8, maximum consecutive DRIVE cycles while another requester is pending (1..255).

Ports:
- clk, input, 1, single clock, rising edge.
- rst_n, input, 1, synchronous active-low reset.
- req, input, N_DRV, request per driver; level, held while the driver wants the bus.
- en, output, N_DRV, tristate enable per driver; one-hot or all-zero, registered.
- grant_id, output, clog2(N_DRV) (min 1), index of current owner; valid only while busy=1.
- busy, output, 1, high while any en bit is high.
- turnaround, output, 1, high during the dead-time gap.

Behaviour:
- Reset: at a clk edge with rst_n=0, the following apply.
  - en=0, busy=0, turnaround=0, grant_id=0.
  - Round-robin pointer = N_DRV-1, so the lowest index has first priority.
  - hold count=0, state=IDLE.
  - Reset asserted mid-DRIVE clears en on that same edge. No gap is owed after reset.
- States: IDLE, DRIVE, GAP.
- IDLE:
  - If any req bit is set, grant the first set bit searching upward from pointer+1 with wraparound.
  - At the next edge: en[k]=1, grant_id=k, busy=1, pointer=k, state=DRIVE.
  - Latency is 1 clock from req sampled to en high.
- DRIVE:
  - hold count increments each cycle and saturates at HOLD_MAX.
  - Release when req[k]=0, or when hold count reaches HOLD_MAX and any other req bit is set.
  - On release edge: en=0, busy=0, turnaround=1, gap count=GAP_CYCLES-1, state=GAP.
- GAP:
  - en stays 0 for exactly GAP_CYCLES clocks; turnaround=1 throughout.
  - After the last gap cycle, evaluate req with the same round-robin search.
  - If any req bit is set: go to DRIVE with the new en and clear turnaround on the same edge.
  - Otherwise: go to IDLE with turnaround=0.
  - The previous owner can win again only if it is the sole requester.
- Invariants:
  - en is never more than one-hot.
  - en never goes 1 in the clock immediately following a cycle where a different en bit was 1.
  - Minimum gap between different owners is GAP_CYCLES cycles of all-zero en.
- Requests that drop while the bus is in GAP are simply not considered. No request is latched or queued.
- Simultaneous req rising: round-robin order only, no fixed priority beyond reset state.
- grant_id holds its last value when busy=0. Monitors must qualify it with busy.

Decomposition:
- Shared package tse_pkg: state enum (IDLE, DRIVE, GAP), N_DRV_MAX=8, HOLD_W=8, GAP_W=4 constants.
- One sub-module: rr_pick (combinational), with inputs req and pointer and outputs hit and idx. It is instantiated once, and verified standalone for all pointer/req combinations at N_DRV=4.

Test Plan:
1. Reset, then req=2'b01 at cycle 3 → en=01 at cycle 4, busy=1, grant_id=0; req low at cycle 10 → en=00 at cycle 11, turnaround=1 for cycles 11-12, IDLE at 13.
2. req=2'b11 from reset release → driver 0 first; drop req[0] → en=00 for exactly 2 cycles, then en=10, grant_id=1; no cycle with en=11 or with 01 directly followed by 10.
3. Both req held constantly, HOLD_MAX=8 → alternating ownership: 8 cycles en=01, 2 cycles 00, 8 cycles 10, 2 cycles 00, repeat ≥3 rounds.
4. Single requester req=01 held 20 cycles → en=01 continuous for all 20, no forced release since no other request is pending.
5. rst_n=0 asserted during DRIVE with en=10 → en=00, busy=0, turnaround=0 on that edge; after release with req=11 → driver 0 granted first.
6. GAP_CYCLES=1 and GAP_CYCLES=15 builds: measured all-zero gap equals parameter exactly; N_DRV=4, req=4'b1010 after owner 1 → next grant is 3, then 1.
